// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, LATENCY wait states, little-endian byte store.
// Optional DMEM_ALIGN_CHECK_EN adds alignment/range/conflict checking reported on mem_err.
module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_BITS   = 10,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  input  logic [2:0]  mem_size,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        busy,
  output logic        mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LAT  = 4'(LATENCY);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        both_q, both_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [7:0]  mem_q [DEPTH_BYTES];

  logic                 capture, commit;
  logic [31:0]          cur_addr, cur_wdata;
  logic [2:0]           cur_size;
  logic                 cur_wr, cur_both;
  logic [ADDR_BITS-1:0] lane [4];
  logic [7:0]           rbyte [4];
  logic [3:0]           wr_be;
  logic [31:0]          rd_val;
  logic                 err_access, err_flag;

  // With LATENCY=0 the access commits on the capture edge, so the live inputs drive it.
  always_comb begin
    capture   = (state_q == IDLE) && (mem_read_req || mem_write_req);
    cur_addr  = (state_q == IDLE) ? mem_address    : addr_q;
    cur_wdata = (state_q == IDLE) ? mem_write_data : wdata_q;
    cur_size  = (state_q == IDLE) ? mem_size       : size_q;
    cur_wr    = (state_q == IDLE) ? mem_write_req  : wr_q;
    cur_both  = (state_q == IDLE) ? (mem_read_req && mem_write_req) : both_q;
    commit    = reset_n && ((capture && (LAT == 4'd0)) ||
                            ((state_q == WAIT) && (cnt_q <= 4'd1)));
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i]  = cur_addr[ADDR_BITS-1:0] + ADDR_BITS'(i);
      rbyte[i] = mem_q[lane[i]];
    end
  end

  always_comb begin
    rd_val = 32'd0;
    case (cur_size)
      3'b000: rd_val = {{24{rbyte[0][7]}}, rbyte[0]};
      3'b001: rd_val = {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]};
      3'b010: rd_val = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
      3'b100: rd_val = {24'd0, rbyte[0]};
      3'b101: rd_val = {16'd0, rbyte[1], rbyte[0]};
      default: rd_val = 32'd0;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic half_acc, word_acc;
  always_comb begin
    half_acc   = (cur_size == 3'b001) || (!cur_wr && (cur_size == 3'b101));
    word_acc   = (cur_size == 3'b010);
    err_access = (half_acc && cur_addr[0]) || (word_acc && (cur_addr[1:0] != 2'b00)) ||
                 (cur_addr >= 32'(DEPTH_BYTES));
    err_flag   = err_access || cur_both;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{cur_addr[31:ADDR_BITS], cur_both};
  assign err_access  = 1'b0;
  assign err_flag    = 1'b0;
`endif

  always_comb begin
    wr_be = 4'b0000;
    if (commit && cur_wr && !err_access) begin
      case (cur_size)
        3'b000:  wr_be = 4'b0001;
        3'b001:  wr_be = 4'b0011;
        3'b010:  wr_be = 4'b1111;
        default: wr_be = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    wr_d    = wr_q;
    both_d  = both_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (capture) begin
        addr_d  = mem_address;
        wdata_d = mem_write_data;
        size_d  = mem_size;
        wr_d    = mem_write_req;
        both_d  = mem_read_req && mem_write_req;
        if (LAT == 4'd0) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT;
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      ready_d = 1'b1;
      busy_d  = 1'b0;
      err_d   = err_flag;
      if (err_access)   rdata_d = 32'd0;
      else if (!cur_wr) rdata_d = rd_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 3'd0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      both_q  <= both_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain; commit is already gated by reset_n.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_be[i]) mem_q[lane[i]] <= cur_wdata[8*i +: 8];
  end

  assign mem_read_data = rdata_q;
  assign mem_ready     = ready_q;
  assign busy          = busy_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 instance driven from a vector table, LATENCY=0 instance for back-to-back.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [2:0]  size = '0;
  logic        rreq = 1'b0, wreq = 1'b0, ready, busy, err;

  logic [31:0] a0 = '0, wd0 = '0, rd0;
  logic [2:0]  sz0 = '0;
  logic        rr0 = 1'b0, wr0 = 1'b0, rdy0, busy0, err0;

  dmem_responder #(.DEPTH_BYTES(1024), .ADDR_BITS(10), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .mem_address(addr), .mem_write_data(wdata),
    .mem_size(size), .mem_read_req(rreq), .mem_write_req(wreq),
    .mem_read_data(rdata), .mem_ready(ready), .busy(busy), .mem_err(err));

  dmem_responder #(.DEPTH_BYTES(1024), .ADDR_BITS(10), .LATENCY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .mem_address(a0), .mem_write_data(wd0),
    .mem_size(sz0), .mem_read_req(rr0), .mem_write_req(wr0),
    .mem_read_data(rd0), .mem_ready(rdy0), .busy(busy0), .mem_err(err0));

  int total = 0, bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Requests are held until mem_ready; inputs are scrambled after capture.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz, output logic [31:0] rdat, output logic er,
                        output int lat, output int bcnt);
    @(negedge clk);
    rreq = r; wreq = w; addr = a; wdata = d; size = sz;
    @(posedge clk);
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (lat == 1) begin addr = ~a; wdata = ~d; size = sz ^ 3'b010; end
    end while (!ready && lat < 20);
    rdat = rdata; er = err;
    rreq = 1'b0; wreq = 1'b0;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [2:0]  size;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic [31:0] rv, last;
    logic        ev;
    int          lat, bcnt, seen;

    tv.push_back('{0, 1, 32'h20,  32'hDEADBEEF, 3'b010, 32'h0, 1'b0});
    tv.push_back('{1, 0, 32'h20,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
    tv.push_back('{0, 1, 32'h30,  32'h0,        3'b010, 32'h0, 1'b0});
    tv.push_back('{0, 1, 32'h31,  32'h80,       3'b000, 32'h0, 1'b0});
    tv.push_back('{1, 0, 32'h31,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
    tv.push_back('{1, 0, 32'h31,  32'h0,        3'b100, 32'h00000080, 1'b0});
    tv.push_back('{0, 1, 32'h32,  32'hBEEF,     3'b001, 32'h0, 1'b0});
    tv.push_back('{1, 0, 32'h32,  32'h0,        3'b001, 32'hFFFFBEEF, 1'b0});
    tv.push_back('{1, 0, 32'h32,  32'h0,        3'b101, 32'h0000BEEF, 1'b0});
    tv.push_back('{1, 0, 32'h30,  32'h0,        3'b010, 32'hBEEF8000, 1'b0});
    tv.push_back('{0, 1, 32'h0,   32'h0,        3'b010, 32'h0, 1'b0});
    tv.push_back('{0, 1, 32'h3FC, 32'h0,        3'b010, 32'h0, 1'b0});
    tv.push_back('{0, 1, 32'h3FE, 32'hA1B2C3D4, 3'b010, 32'h0, ALN});
    tv.push_back('{1, 0, 32'h0,   32'h0,        3'b001, ALN ? 32'h0 : 32'hFFFFA1B2, 1'b0});
    tv.push_back('{1, 0, 32'h3FF, 32'h0,        3'b100, ALN ? 32'h0 : 32'h000000C3, 1'b0});
    tv.push_back('{0, 1, 32'h24,  32'h0,        3'b010, 32'h0, 1'b0});
    tv.push_back('{1, 0, 32'h22,  32'h0,        3'b010, ALN ? 32'h0 : 32'h0000DEAD, ALN});
    tv.push_back('{0, 1, 32'h400, 32'h99887766, 3'b010, 32'h0, ALN});
    tv.push_back('{1, 0, 32'h0,   32'h0,        3'b010, ALN ? 32'h0 : 32'h99887766, 1'b0});
    tv.push_back('{0, 1, 32'h20,  32'hFFFFFFFF, 3'b011, 32'h0, 1'b0});
    tv.push_back('{1, 0, 32'h20,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
    tv.push_back('{1, 0, 32'h20,  32'h0,        3'b011, 32'h0, 1'b0});
    tv.push_back('{1, 1, 32'h44,  32'h12345678, 3'b010, 32'h0, ALN});
    tv.push_back('{1, 0, 32'h44,  32'h0,        3'b010, 32'h12345678, 1'b0});

    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", {31'd0, ready}, 32'h0);
    check("rst_busy",  {31'd0, busy},  32'h0);
    check("rst_err",   {31'd0, err},   32'h0);
    check("rst0_all",  {rd0[28:0], rdy0, busy0, err0}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {29'd0, ready, busy, err}, 32'h0);

    last = 32'h0;
    for (int i = 0; i < tv.size(); i++) begin
      access(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].size, rv, ev, lat, bcnt);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd2);
      check($sformatf("v%0d_err", i), {31'd0, ev}, {31'd0, tv[i].exp_err});
      if (!tv[i].wr) begin
        check($sformatf("v%0d_rdata", i), rv, tv[i].exp_rd);
        last = tv[i].exp_rd;
      end else if (!tv[i].exp_err) begin
        check($sformatf("v%0d_wr_keeps_rdata", i), rv, last);
      end
    end

    access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 3'b010, rv, ev, lat, bcnt);
    check("pre_abort_lat", 32'(lat), 32'd3);
    @(negedge clk);
    wreq = 1'b1; addr = 32'h10; wdata = 32'h11223344; size = 3'b010;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_wait_busy", {31'd0, busy}, 32'h1);
    reset_n = 1'b0; wreq = 1'b0;
    #1;
    check("abort_async_clear", {29'd0, ready, busy, err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready) seen++;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, rv, ev, lat, bcnt);
    check("abort_no_commit", rv, 32'hCAFEF00D);

    @(negedge clk);
    rr0 = 1'b1; wr0 = 1'b1; a0 = 32'h40; wd0 = 32'h5A5A5A5A; sz0 = 3'b010;
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("l0_ready_c%0d", k), {31'd0, rdy0}, {31'd0, k[0]});
      check($sformatf("l0_busy_c%0d", k), {31'd0, busy0}, 32'h0);
      if (rdy0) begin
        seen++;
        check($sformatf("l0_err_c%0d", k), {31'd0, err0}, {31'd0, ALN});
      end
    end
    rr0 = 1'b0; wr0 = 1'b0;
    check("l0_pulses", 32'(seen), 32'd4);
    @(negedge clk);
    rr0 = 1'b1; sz0 = 3'b010; a0 = 32'h40;
    @(posedge clk);
    @(negedge clk);
    rr0 = 1'b0;
    check("l0_rd_ready", {31'd0, rdy0}, 32'h1);
    check("l0_rd_data", rd0, 32'h5A5A5A5A);
    check("l0_rd_err", {31'd0, err0}, 32'h0);
    @(negedge clk);
    check("l0_ready_drops", {31'd0, rdy0}, 32'h0);
    check("l0_rdata_holds", rd0, 32'h5A5A5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that sits on the far side of the pipeline's data-memory interface, opposite the MEM stage initiator.
- Accepts one read or write request at a time and applies a configurable number of wait states.
- Performs byte, half-word or word little-endian access into an internal byte array, then returns a one-cycle mem_ready pulse with the read data.
- Lets the core be exercised with realistic memory latency instead of zero-wait storage.

Parameters:
- DEPTH_BYTES, 1024: size of the byte-addressable storage.
- ADDR_BITS, 10: index width; equals log2(DEPTH_BYTES).
- LATENCY, 2: wait-state cycles between request capture and response; legal range 0..15.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- mem_address  input  32  byte address from the initiator
- mem_write_data  input  32  store data; bits [7:0] go to the lowest byte address
- mem_size  input  3  access type, funct3 encoding
- mem_read_req  input  1  read request, held by the initiator until mem_ready
- mem_write_req  input  1  write request, held by the initiator until mem_ready
- mem_read_data  output  32  load result, valid while mem_ready=1
- mem_ready  output  1  one-cycle completion pulse
- busy  output  1  high from request capture until mem_ready is asserted
- mem_err  output  1  access-error flag, valid with mem_ready

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, mem_ready=0, busy=0, mem_err=0, mem_read_data=0, wait counter=0. Storage contents are not cleared.
- Reset mid-transaction aborts it: no write commits, and no mem_ready is issued after release.
- FSM states: IDLE, WAIT, RESP.
- IDLE: at a clk edge where mem_read_req or mem_write_req is 1, capture address, write data, size and operation. busy=1.
  - LATENCY=0: go to RESP.
  - Otherwise: load counter with LATENCY and go to WAIT.
- WAIT: counter decrements every cycle. At the edge where counter==1, go to RESP.
- Entry into RESP (single edge):
  - Writes commit to storage.
  - Reads register mem_read_data.
  - mem_ready=1, busy=0.
- RESP lasts exactly one cycle, then IDLE. Requests still high during the RESP cycle are ignored, so back-to-back throughput is one access per LATENCY+2 cycles. A request captured at edge T yields mem_ready high in cycle T+LATENCY+1.
- mem_read_data holds its last value after mem_ready drops. A write response leaves mem_read_data unchanged.
- If mem_read_req and mem_write_req are both 1 at capture, the request is treated as a write.
- Indexing: byte index = mem_address[ADDR_BITS-1:0]. Multi-byte lanes (+1, +2, +3) wrap modulo DEPTH_BYTES.
- Read encoding (little-endian):
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Any other code returns 0.
- Write encoding: 000 SB, 001 SH, 010 SW. Any other code writes nothing but still completes with mem_ready.
- Input changes after capture have no effect on the transaction in flight.

Optional Feature:
- DMEM_ALIGN_CHECK_EN defined:
  - An access is erroneous if it is LH/LHU/SH with address[0]≠0, LW/SW with address[1:0]≠0, or address ≥ DEPTH_BYTES.
  - An erroneous access suppresses the write, returns mem_read_data=0, and drives mem_err=1 for the mem_ready cycle only.
  - Simultaneous read+write request also sets mem_err (the write still proceeds if otherwise legal).
- Undefined: mem_err is tied to 0, no checks are made, and accesses proceed with wrap-around indexing.

Test Plan:
- Reset behaviour: reset_n low for 3 cycles, then release. Expect all outputs 0. Assert reset_n low in a WAIT cycle of a SW 0x11223344 to address 0x10; after release, LW 0x10 returns the prior contents and no mem_ready appears for the aborted request.
- Word round trip, LATENCY=2: SW 0xDEADBEEF to 0x20, captured at edge T → mem_ready high in cycle T+3 only, busy high T..T+2. Then LW 0x20 returns 0xDEADBEEF.
- Sub-word access: SB 0x80 to 0x31 → LB 0x31 = 0xFFFFFF80, LBU 0x31 = 0x00000080. SH 0xBEEF to 0x32 → LH 0x32 = 0xFFFFBEEF, LHU 0x32 = 0x0000BEEF.
- Wrap-around: SW 0xA1B2C3D4 to 0x3FE (DEPTH 1024) → bytes 0x3FE=D4, 0x3FF=C3, 0x000=B2, 0x001=A1. LH 0x000 returns 0xFFFFA1B2.
- LATENCY=0 back-to-back with requests held high: mem_ready pulses every 2nd cycle and each pulse completes exactly one transaction. Simultaneous read+write to 0x40 with 0x5A5A5A5A → LW 0x40 returns 0x5A5A5A5A.
- With DMEM_ALIGN_CHECK_EN: LW 0x22 → mem_err=1 and mem_read_data=0 with mem_ready. SW to 0x400 → mem_err=1 and word 0x000 unchanged. Without the macro, mem_err stays 0 for both.
